// File: rtl/sk9822_frame_tx.sv
// SK9822 frame transmitter: reads N_LEDS words from the LED dpram and shifts out start, LED and end frames.
// Optional macro SK9822_PER_LED_BRIGHTNESS_EN takes the 5-bit brightness from rdata[28:24] instead of BRIGHT.
module sk9822_frame_tx #(
  parameter int unsigned N_LEDS   = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned END_BITS = 40,
  parameter logic [4:0]  BRIGHT   = 5'h1F
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [ADDR_W-1:0] raddr,
  input  logic [31:0]       rdata,
  output logic              led_ck,
  output logic              led_data
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_FETCH,
    S_LED,
    S_END,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DIV_W-1:0]  r_div;
  logic [5:0]        r_bit;
  logic [ADDR_W-1:0] r_idx;
  logic              r_fcyc;
  logic [31:0]       r_sh;

  logic [4:0]  w_bright;
  logic [31:0] w_word;
  logic        w_div_last;
  logic        w_bit_last;
  logic        w_idx_last;

`ifdef SK9822_PER_LED_BRIGHTNESS_EN
  logic w_unused_rdata;
  assign w_bright       = rdata[28:24];
  assign w_unused_rdata = ^rdata[31:29];
`else
  logic w_unused_rdata;
  assign w_bright       = BRIGHT;
  assign w_unused_rdata = ^rdata[31:24];
`endif

  assign w_word     = {3'b111, w_bright, rdata[23:0]};
  assign w_div_last = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_bit_last = (r_bit == ((r_state == S_END) ? 6'(END_BITS - 1) : 6'd31));
  assign w_idx_last = (r_idx == ADDR_W'(N_LEDS - 1));

  // Frame sequencer; led_ck always returns low before any state change
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_div    <= '0;
      r_bit    <= '0;
      r_idx    <= '0;
      r_fcyc   <= 1'b0;
      r_sh     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      re       <= 1'b0;
      raddr    <= '0;
      led_ck   <= 1'b0;
      led_data <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_START;
            busy     <= 1'b1;
            r_bit    <= '0;
            r_div    <= '0;
            led_ck   <= 1'b0;
            led_data <= 1'b0;
          end
        end
        S_START, S_LED, S_END: begin
          if (!w_div_last) begin
            r_div <= r_div + DIV_W'(1);
          end else begin
            r_div <= '0;
            if (!led_ck) begin
              led_ck <= 1'b1;
            end else begin
              led_ck <= 1'b0;
              if (!w_bit_last) begin
                r_bit    <= r_bit + 6'd1;
                r_sh     <= {r_sh[30:0], 1'b0};
                led_data <= (r_state == S_LED) ? r_sh[30] : 1'b0;
              end else begin
                r_bit    <= '0;
                led_data <= 1'b0;
                case (r_state)
                  S_START: begin
                    r_state <= S_FETCH;
                    r_idx   <= '0;
                    raddr   <= '0;
                    re      <= 1'b1;
                    r_fcyc  <= 1'b0;
                  end
                  S_LED: begin
                    if (w_idx_last) begin
                      r_state <= S_END;
                    end else begin
                      r_state <= S_FETCH;
                      r_idx   <= r_idx + ADDR_W'(1);
                      raddr   <= r_idx + ADDR_W'(1);
                      re      <= 1'b1;
                      r_fcyc  <= 1'b0;
                    end
                  end
                  default: begin
                    r_state <= S_DONE;
                    done    <= 1'b1;
                  end
                endcase
              end
            end
          end
        end
        // Cycle 0 holds re; cycle 1 sees rdata and loads the shifter
        S_FETCH: begin
          if (!r_fcyc) begin
            re     <= 1'b0;
            r_fcyc <= 1'b1;
          end else begin
            r_sh     <= w_word;
            led_data <= w_word[31];
            r_div    <= '0;
            r_bit    <= '0;
            r_state  <= S_LED;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sk9822_frame_tx.sv
// Directed bench: a 2-LED/CLK_DIV=1 instance and a default instance, each fed by a small RAM model.
module tb_sk9822_frame_tx;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, re_a, ck_a, dat_a;
  logic busy_b, done_b, re_b, ck_b, dat_b;
  logic [3:0] raddr_a, raddr_b;
  logic [31:0] rdata_a = '0, rdata_b = '0;
  logic [31:0] mem_a [0:15];
  logic [31:0] mem_b [0:15];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sk9822_frame_tx #(.N_LEDS(2), .ADDR_W(4), .CLK_DIV(1), .END_BITS(32), .BRIGHT(5'h1F)) dut_a (
    .clk(clk), .resetn(resetn), .start(start_a), .busy(busy_a), .done(done_a), .re(re_a),
    .raddr(raddr_a), .rdata(rdata_a), .led_ck(ck_a), .led_data(dat_a));

  sk9822_frame_tx dut_b (
    .clk(clk), .resetn(resetn), .start(start_b), .busy(busy_b), .done(done_b), .re(re_b),
    .raddr(raddr_b), .rdata(rdata_b), .led_ck(ck_b), .led_data(dat_b));

  always @(posedge clk) begin
    if (re_a) rdata_a <= mem_a[raddr_a];
    if (re_b) rdata_b <= mem_b[raddr_b];
  end

  // Edge/bit capture, sampled on the falling clk edge
  int rise_a = 0, done_cnt_a = 0, re_cnt_a = 0;
  logic [3:0] raddr_log_a [0:15];
  logic bits_a [0:1023];
  logic ck_a_q = 1'b0;
  int rise_b = 0, done_cnt_b = 0, lo4 = 0, lo6 = 0, lo_bad = 0, hi_bad = 0;
  int hi_run = 0, lo_run = 0;
  logic bits_b [0:4095];
  logic ck_b_q = 1'b0;

  always @(negedge clk) begin
    if (ck_a && !ck_a_q) begin
      if (rise_a < 1024) bits_a[rise_a] = dat_a;
      rise_a++;
    end
    ck_a_q = ck_a;
    if (done_a) done_cnt_a++;
    if (re_a) begin
      if (re_cnt_a < 16) raddr_log_a[re_cnt_a] = raddr_a;
      re_cnt_a++;
    end
    if (ck_b && !ck_b_q) begin
      if (rise_b < 4096) bits_b[rise_b] = dat_b;
      rise_b++;
      if (lo_run == 4) lo4++;
      else if (lo_run == 6) lo6++;
      else lo_bad++;
      lo_run = 0;
    end
    if (!ck_b && ck_b_q) begin
      if (hi_run != 4) hi_bad++;
      hi_run = 0;
    end
    if (ck_b) hi_run++;
    else if (busy_b) lo_run++;
    else lo_run = 0;
    ck_b_q = ck_b;
    if (done_b) done_cnt_b++;
  end

  task automatic test_reset();
    int bad = 0;
    int r0a, r0b;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    r0a = rise_a; r0b = rise_b;
    repeat (100) begin
      @(negedge clk);
      if ({ck_a, dat_a, re_a, busy_a, done_a, ck_b, dat_b, re_b, busy_b, done_b} !== 10'b0) bad++;
      if (raddr_a !== 4'd0 || raddr_b !== 4'd0) bad++;
    end
    n_tests++;
    if (bad !== 0) begin n_fail++; $display("FAIL reset_idle: %0d bad cycles, expected 0", bad); end
    n_tests++;
    if ((rise_a - r0a) + (rise_b - r0b) !== 0) begin
      n_fail++; $display("FAIL reset_edges: %0d led_ck edges, expected 0", (rise_a - r0a) + (rise_b - r0b));
    end
  endtask

  task automatic test_small_frame();
    int base, d0, e0, t;
    logic [31:0] w;
    logic [31:0] exp0, exp1;
    int zbad = 0;
`ifdef SK9822_PER_LED_BRIGHTNESS_EN
    exp0 = 32'hE0FF0000; exp1 = 32'hE00000AA;
`else
    exp0 = 32'hFFFF0000; exp1 = 32'hFF0000AA;
`endif
    base = rise_a; d0 = done_cnt_a; e0 = re_cnt_a;
    start_a = 1'b1; @(negedge clk); start_a = 1'b0;
    n_tests++;
    if (busy_a !== 1'b1) begin n_fail++; $display("FAIL small_busy_rise: busy=%0b expected 1", busy_a); end
    t = 0;
    while (done_cnt_a == d0 && t < 2000) begin @(negedge clk); t++; end
    n_tests++;
    if (done_cnt_a == d0) begin n_fail++; $display("FAIL small_timeout: no done, expected done"); end
    repeat (20) @(negedge clk);
    n_tests++;
    if (rise_a - base !== 128) begin n_fail++; $display("FAIL small_len: %0d edges, expected 128", rise_a - base); end
    for (int k = 0; k < 32; k++) begin
      if (bits_a[base + k] !== 1'b0) zbad++;
      if (bits_a[base + 96 + k] !== 1'b0) zbad++;
    end
    n_tests++;
    if (zbad !== 0) begin n_fail++; $display("FAIL small_start_end: %0d nonzero bits, expected 0", zbad); end
    for (int k = 0; k < 32; k++) w[31-k] = bits_a[base + 32 + k];
    n_tests++;
    if (w !== exp0) begin n_fail++; $display("FAIL small_led0: got %08h expected %08h", w, exp0); end
    for (int k = 0; k < 32; k++) w[31-k] = bits_a[base + 64 + k];
    n_tests++;
    if (w !== exp1) begin n_fail++; $display("FAIL small_led1: got %08h expected %08h", w, exp1); end
    n_tests++;
    if (done_cnt_a - d0 !== 1) begin n_fail++; $display("FAIL small_done: %0d pulses, expected 1", done_cnt_a - d0); end
    n_tests++;
    if (busy_a !== 1'b0) begin n_fail++; $display("FAIL small_busy_fall: busy=%0b expected 0", busy_a); end
    n_tests++;
    if (re_cnt_a - e0 !== 2) begin n_fail++; $display("FAIL small_re_count: %0d, expected 2", re_cnt_a - e0); end
    n_tests++;
    if (raddr_log_a[e0] !== 4'd0 || raddr_log_a[e0+1] !== 4'd1) begin
      n_fail++; $display("FAIL small_raddr: got %0d,%0d expected 0,1", raddr_log_a[e0], raddr_log_a[e0+1]);
    end
  endtask

  task automatic test_default_frame();
    int base, d0, t, l4, l6, lb, hb;
    int zbad = 0;
    logic [31:0] w;
    logic [31:0] exp0, exp15;
`ifdef SK9822_PER_LED_BRIGHTNESS_EN
    exp0 = 32'hE5123456; exp15 = 32'hEA00FF0F;
`else
    exp0 = 32'hFF123456; exp15 = 32'hFF00FF0F;
`endif
    base = rise_b; d0 = done_cnt_b; l4 = lo4; l6 = lo6; lb = lo_bad; hb = hi_bad;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    t = 0;
    while (done_cnt_b == d0 && t < 6000) begin @(negedge clk); t++; end
    n_tests++;
    if (done_cnt_b == d0) begin n_fail++; $display("FAIL dflt_timeout: no done, expected done"); end
    repeat (10) @(negedge clk);
    n_tests++;
    if (rise_b - base !== 584) begin n_fail++; $display("FAIL dflt_len: %0d edges, expected 584", rise_b - base); end
    n_tests++;
    if (hi_bad - hb !== 0) begin n_fail++; $display("FAIL dflt_high_phase: %0d bad, expected 0", hi_bad - hb); end
    n_tests++;
    if (lo4 - l4 !== 568 || lo6 - l6 !== 16 || lo_bad - lb !== 0) begin
      n_fail++; $display("FAIL dflt_low_phase: 4c=%0d 6c=%0d other=%0d, expected 568/16/0", lo4 - l4, lo6 - l6, lo_bad - lb);
    end
    for (int k = 0; k < 32; k++) if (bits_b[base + k] !== 1'b0) zbad++;
    for (int k = 0; k < 40; k++) if (bits_b[base + 544 + k] !== 1'b0) zbad++;
    n_tests++;
    if (zbad !== 0) begin n_fail++; $display("FAIL dflt_start_end: %0d nonzero bits, expected 0", zbad); end
    for (int k = 0; k < 32; k++) w[31-k] = bits_b[base + 32 + k];
    n_tests++;
    if (w !== exp0) begin n_fail++; $display("FAIL dflt_led0: got %08h expected %08h", w, exp0); end
    for (int k = 0; k < 32; k++) w[31-k] = bits_b[base + 512 + k];
    n_tests++;
    if (w !== exp15) begin n_fail++; $display("FAIL dflt_led15: got %08h expected %08h", w, exp15); end
  endtask

  task automatic test_start_ignored();
    int base, d0, t;
    base = rise_b; d0 = done_cnt_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    t = 0;
    while (rise_b - base < 100 && t < 2000) begin @(negedge clk); t++; end
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    t = 0;
    while (!done_b && t < 6000) begin @(negedge clk); t++; end
    n_tests++;
    if (done_b !== 1'b1) begin n_fail++; $display("FAIL ign_timeout: done=%0b, expected 1", done_b); end
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    repeat (100) @(negedge clk);
    n_tests++;
    if (rise_b - base !== 584) begin n_fail++; $display("FAIL ign_len: %0d edges, expected 584", rise_b - base); end
    n_tests++;
    if (done_cnt_b - d0 !== 1) begin n_fail++; $display("FAIL ign_done: %0d pulses, expected 1", done_cnt_b - d0); end
    n_tests++;
    if (busy_b !== 1'b0) begin n_fail++; $display("FAIL ign_busy: busy=%0b expected 0", busy_b); end
  endtask

  task automatic test_reset_abort();
    int base, d0, t;
    base = rise_b;
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    t = 0;
    while (rise_b - base < 300 && t < 4000) begin @(negedge clk); t++; end
    resetn = 1'b0;
    #1;
    n_tests++;
    if ({ck_b, dat_b, re_b, busy_b, done_b} !== 5'b0) begin
      n_fail++; $display("FAIL abort_outputs: got %05b expected 00000", {ck_b, dat_b, re_b, busy_b, done_b});
    end
    @(negedge clk);
    resetn = 1'b1;
    base = rise_b; d0 = done_cnt_b;
    repeat (2000) @(negedge clk);
    n_tests++;
    if (rise_b - base !== 0 || done_cnt_b - d0 !== 0) begin
      n_fail++; $display("FAIL abort_quiet: %0d edges %0d done, expected 0 0", rise_b - base, done_cnt_b - d0);
    end
    start_b = 1'b1; @(negedge clk); start_b = 1'b0;
    t = 0;
    while (done_cnt_b == d0 && t < 6000) begin @(negedge clk); t++; end
    repeat (10) @(negedge clk);
    n_tests++;
    if (rise_b - base !== 584 || done_cnt_b - d0 !== 1) begin
      n_fail++; $display("FAIL abort_restart: %0d edges %0d done, expected 584 1", rise_b - base, done_cnt_b - d0);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = 32'h0;
      mem_b[i] = 32'h00010203 * i;
    end
    mem_a[0]  = 32'h00FF0000;
    mem_a[1]  = 32'h000000AA;
    mem_b[0]  = 32'h05123456;
    mem_b[15] = 32'hAA00FF0F;
    test_reset();
    test_small_frame();
    test_default_frame();
    test_start_ignored();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
